// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 request port among NUM_REQ L1 controllers.
// One transaction is locked per grant; the L2 acknowledgement is routed back to its owner only.
module l2_port_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LINE_WIDTH    = 128
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_read,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0]               req_wb,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_wbdata,
  output logic [NUM_REQ-1:0]               ack_ready,
  output logic [NUM_REQ-1:0]               ack_write,
  output logic [NUM_REQ-1:0]               ack_wb,
  output logic [LINE_WIDTH-1:0]            fill_data,
  output logic [ADDRESS_WIDTH-1:0]         l2_addr,
  output logic                             l2_read_req,
  output logic                             l2_write_req,
  output logic                             l2_wb_req,
  output logic [DATA_WIDTH-1:0]            l2_wdata,
  output logic [LINE_WIDTH-1:0]            l2_wbdata,
  input  logic                             l2_ready,
  input  logic                             l2_write_verified,
  input  logic                             l2_wb_verified,
  input  logic [LINE_WIDTH-1:0]            l2_fill_data,
  output logic                             gnt_valid,
  output logic [1:0]                       gnt_id
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               rr_ptr_q, rr_ptr_d;
  logic [1:0]               gnt_id_q, gnt_id_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]    wbdata_q, wbdata_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     wb_q, wb_d;

  logic [3:0] rd4, wr4, wb4, pend4;
  logic       win_found;
  logic [1:0] win_id;
  logic       ack_hit;
  logic [3:0] ack_onehot;

  // Request vectors widened to four lanes so a 2-bit index is always in range.
  always_comb begin : p_arb
    logic [1:0] idx;
    rd4       = '0;
    wr4       = '0;
    wb4       = '0;
    rd4[NUM_REQ-1:0] = req_read;
    wr4[NUM_REQ-1:0] = req_write;
    wb4[NUM_REQ-1:0] = req_wb;
    pend4     = rd4 | wr4 | wb4;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 2'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && pend4[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign ack_hit = (rd_q & l2_ready) | (wr_q & l2_write_verified) | (wb_q & l2_wb_verified);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wbdata_d = wbdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wb_d     = wb_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d  = StBusy;
          gnt_id_d = win_id;
          addr_d   = req_addr[32'(win_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          wdata_d  = req_wdata[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
          wbdata_d = req_wbdata[32'(win_id)*LINE_WIDTH +: LINE_WIDTH];
          // Only the highest-priority type is taken; a second type waits a full rotation.
          if (wb4[win_id]) begin
            wb_d = 1'b1;
          end else if (wr4[win_id]) begin
            wr_d = 1'b1;
          end else begin
            rd_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (ack_hit) begin
          state_d  = StRelease;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          wb_d     = 1'b0;
          rr_ptr_d = 2'((32'(gnt_id_q) + 32'd1) % NUM_REQ);
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbdata_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wbdata_q <= wbdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wb_q     <= wb_d;
    end
  end

  always_comb begin
    ack_onehot = 4'b0001 << gnt_id_q;
    ack_ready  = '0;
    ack_write  = '0;
    ack_wb     = '0;
    if (state_q == StBusy) begin
      if (rd_q && l2_ready)          ack_ready = ack_onehot[NUM_REQ-1:0];
      if (wr_q && l2_write_verified) ack_write = ack_onehot[NUM_REQ-1:0];
      if (wb_q && l2_wb_verified)    ack_wb    = ack_onehot[NUM_REQ-1:0];
    end
  end

  assign fill_data    = l2_fill_data;
  assign l2_addr      = addr_q;
  assign l2_wdata     = wdata_q;
  assign l2_wbdata    = wbdata_q;
  assign l2_read_req  = rd_q;
  assign l2_write_req = wr_q;
  assign l2_wb_req    = wb_q;
  assign gnt_valid    = (state_q == StBusy);
  assign gnt_id       = gnt_id_q;

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Round-robin arbiter that shares the single L2 request port among up to four L1 cache controllers (one per processor ID). It sits between the per-processor L1 FSMs and the L2 controller. It locks a grant per transaction (read fill, word write-through, line write-back), latches the winner's address and data, and routes the L2 acknowledgement back to that requester only.

## Interface
Parameters:
- NUM_REQ, 4, number of L1 requesters (2..4); requester index equals processor ID
- ADDRESS_WIDTH, 32, address width
- DATA_WIDTH, 32, write-through word width
- LINE_WIDTH, 128, cache line width (equals MAIN_MEMORY_DATA_WIDTH)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_read  in  NUM_REQ  per-requester read-fill request (level)
- req_write  in  NUM_REQ  per-requester word write-through request (level)
- req_wb  in  NUM_REQ  per-requester line write-back request (level)
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write words
- req_wbdata  in  NUM_REQ*LINE_WIDTH  packed write-back lines
- ack_ready  out  NUM_REQ  read fill complete (mirrors L2 ready), one-hot
- ack_write  out  NUM_REQ  write-through verified, one-hot
- ack_wb  out  NUM_REQ  write-back verified, one-hot
- fill_data  out  LINE_WIDTH  L2 fill line, broadcast to all requesters
- l2_addr  out  ADDRESS_WIDTH  latched address of granted transaction
- l2_read_req / l2_write_req / l2_wb_req  out  1 each  request to L2, at most one high
- l2_wdata  out  DATA_WIDTH  latched write word
- l2_wbdata  out  LINE_WIDTH  latched write-back line
- l2_ready / l2_write_verified / l2_wb_verified  in  1 each  L2 acknowledgements
- l2_fill_data  in  LINE_WIDTH  L2 fill line
- gnt_valid  out  1  a transaction is locked
- gnt_id  out  2  index of locked requester

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: a requester is pending if any of its three request bits is high. Search starts at rr_ptr and wraps modulo NUM_REQ; the first pending requester wins. On the next clock edge:
  - latch its address, wdata and wbdata;
  - latch its type with priority wb > write > read;
  - set gnt_id, go to BUSY.
  With nothing pending, stay in IDLE.
- BUSY:
  - Exactly one l2_*_req is high (the latched type), driven from registers.
  - The matching L2 ack is passed combinationally to bit gnt_id of the matching ack_* vector, in the same cycle.
  - Acks of a non-matching type are ignored.
  - On the matching ack: next state RELEASE, rr_ptr <= gnt_id+1 mod NUM_REQ.
- RELEASE: one cycle with all l2_*_req low and no new grant. This lets the L1 FSM drop its registered request. Then go to IDLE.
- Grant is locked: if the requester deasserts its request while in BUSY, the L2 request still stays high until acked, and the ack pulse is still delivered.
- A requester holding two request types: the lower-priority type is served on a later grant, after the other requesters in rotation.
- fill_data = l2_fill_data at all times.
- ack_* bits are never high outside BUSY.
- Requester bits at index ≥ NUM_REQ do not exist; gnt_id < NUM_REQ always.

## Timing
- Reset (asynchronous):
  - state=IDLE, rr_ptr=0, gnt_valid=0, gnt_id=0.
  - All l2_*_req=0; l2_addr, l2_wdata, l2_wbdata=0.
  - All ack_* = 0.
- Reset asserted mid-BUSY drops the L2 request immediately; the transaction is discarded with no ack.
- Request seen in IDLE at edge N: l2_*_req and gnt_valid high from edge N+1.
- With L2 acking in the first BUSY cycle, the transaction occupies 3 cycles (IDLE, BUSY, RELEASE). Maximum grant rate is one per 3 cycles.
- gnt_valid is high only in BUSY.
- Worst-case wait for a continuously requesting requester: NUM_REQ−1 other transactions.

## Test plan
- Single read: requester 1 raises req_read, addr 0x4000_0040. Required: l2_read_req and l2_addr=0x4000_0040 one cycle later. l2_ready high with l2_fill_data=0xA5..A5 gives ack_ready=4'b0010 in the same cycle. RELEASE follows, then IDLE.
- Round robin: all four requesters raise req_read together, L2 acks immediately. Required grant order is 0,1,2,3,0, one grant every 3 cycles.
- Type priority: requester 2 raises req_wb and req_write together. Required: write-back granted first with l2_wbdata equal to its line; write is granted later, only after the other pending requesters.
- Held grant: requester 3's l2_write_req waits 10 cycles for l2_write_verified while requester 0 requests. Required: l2_addr stays stable, no grant to 0 until requester 3's ack plus the RELEASE cycle.
- Abort: requester 0 drops req_read in the second BUSY cycle. Required: l2_read_req stays high; on l2_ready, ack_ready[0] pulses.
- Reset mid-BUSY: assert reset during an outstanding write. Required: all outputs 0 asynchronously and rr_ptr=0; after release, requester 0 wins first.
